// File: rtl/alu_ctrl_seq_pkg.sv
// Shared types and constants for the multicycle ALU control sequencer.
// States, mux/ALU codes, opcode/funct values and the per-state output decode.
package alu_ctrl_seq_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_ADDR     = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_MD_START = 4'd12,
        S_MD_WAIT  = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        ALU_NONE = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_SLT  = 3'b111
    } alu_op_t;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_REG = 2'b01;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        alu_op_t    alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       md_start;
    } ctrl_t;

    // Moore decode: everything the datapath sees while sitting in state s.
    function automatic ctrl_t state_outs(state_t s, alu_op_t r_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
                c.src_a    = SRCA_PC;
                c.src_b    = SRCB_FOUR;
                c.alu_op   = ALU_ADD;
            end
            S_DECODE: begin
                c.src_a  = SRCA_PC;
                c.src_b  = SRCB_IMM2;
                c.alu_op = ALU_ADD;
            end
            S_EXEC_R: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_RT;
                c.alu_op = r_op;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                c.src_a  = SRCA_REG;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALU_ADD;
            end
            S_WB_I: c.reg_write = 1'b1;
            S_MEM_RD: c.mem_read = 1'b1;
            S_MEM_WR: c.mem_write = 1'b1;
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                c.src_a         = SRCA_REG;
                c.src_b         = SRCB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
            end
            S_MD_START: c.md_start = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Bundle between the control sequencer and the datapath.
// master = controller side, slave = datapath/IR side.
interface alu_ctrl_seq_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       md_busy;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       md_start;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, md_busy,
        output ALUSrcA, ALUSrcB, ALUOp,
        output PCWrite, PCWriteCond, IRWrite,
        output MemRead, MemWrite, RegWrite,
        output RegDst, MemtoReg, md_start,
        output illegal_op, state_dbg
    );

    modport slave (
        output opcode, funct, zero, md_busy,
        input  ALUSrcA, ALUSrcB, ALUOp,
        input  PCWrite, PCWriteCond, IRWrite,
        input  MemRead, MemWrite, RegWrite,
        input  RegDst, MemtoReg, md_start,
        input  illegal_op, state_dbg
    );
endinterface

// File: rtl/alu_ctrl_seq_funct_dec.sv
// R-type funct decoder: ALU operation, mult/div flag and legality.
// Purely combinational; mult/div carry no ALU operation.
module alu_funct_dec
    import alu_ctrl_seq_pkg::*;
(
    input  logic [5:0] funct_i,
    output alu_op_t    alu_op_o,
    output logic       is_md_o,
    output logic       legal_o
);

    // Map funct to ALU op; anything unlisted is flagged illegal.
    always_comb begin
        alu_op_o = ALU_NONE;
        is_md_o  = 1'b0;
        legal_o  = 1'b1;
        unique case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_MULT: is_md_o  = 1'b1;
            FN_DIV:  is_md_o  = 1'b1;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multicycle control FSM sequencing ALU muxes and write strobes.
// Outputs are registered alongside the state, so they follow it exactly.
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input logic           clk,
    input logic           reset,
    alu_ctrl_seq_if.master bus
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [5:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ill_q, ill_d;
    ctrl_t         ctrl_q;

    alu_op_t dec_op;
    logic    dec_md;
    logic    dec_legal;

    alu_funct_dec u_fdec (
        .funct_i  (bus.funct),
        .alu_op_o (dec_op),
        .is_md_o  (dec_md),
        .legal_o  (dec_legal)
    );

    logic is_r, r_md, r_alu;
    logic is_addi, is_mem, is_beq;

    assign is_r    = (bus.opcode == OP_R);
    assign r_md    = is_r & dec_legal & dec_md;
    assign r_alu   = is_r & dec_legal & ~dec_md;
    assign is_addi = (bus.opcode == OP_ADDI);
    assign is_mem  = (bus.opcode == OP_LW) | (bus.opcode == OP_SW);
    assign is_beq  = (bus.opcode == OP_BEQ);

    // Next-state selection, opcode latch and memory latency counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ill_d   = 1'b0;
        unique case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                unique case (1'b1)
                    r_md:    state_d = S_MD_START;
                    r_alu:   state_d = S_EXEC_R;
                    is_addi: state_d = S_EXEC_I;
                    is_mem:  state_d = S_ADDR;
                    is_beq:  state_d = S_BRANCH;
                    default: begin
                        state_d = S_FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   state_d = S_FETCH;
            S_ADDR: begin
                cnt_d   = CNT_LOAD;
                state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (cnt_q == '0) state_d = S_WB_MEM;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_MEM_WR: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_MD_START: state_d = S_MD_WAIT;
            S_MD_WAIT:  state_d = bus.md_busy ? S_MD_WAIT : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State and registered outputs; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            op_q    <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            ctrl_q  <= state_outs(state_d, dec_op);
        end
    end

    assign bus.ALUSrcA     = ctrl_q.src_a;
    assign bus.ALUSrcB     = ctrl_q.src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCWrite     = ctrl_q.pc_write;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.IRWrite     = ctrl_q.ir_write;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.md_start    = ctrl_q.md_start;
    assign bus.illegal_op  = ill_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq (MEM_LAT=2).
// Flag vector: {PCW,PCWC,IRW,MR,MW,RW,RD,M2R,mds,ill}.
module tb_alu_ctrl_seq;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    alu_ctrl_seq_if bus ();

    alu_ctrl_seq #(.MEM_LAT(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] FL_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] FL_FETCH = 10'b10_1100_0000;
    localparam logic [9:0] FL_FILL  = 10'b10_1100_0001;
    localparam logic [9:0] FL_WBR   = 10'b00_0001_1000;
    localparam logic [9:0] FL_WBI   = 10'b00_0001_0000;
    localparam logic [9:0] FL_MRD   = 10'b00_0100_0000;
    localparam logic [9:0] FL_MWR   = 10'b00_0010_0000;
    localparam logic [9:0] FL_WBM   = 10'b00_0001_0100;
    localparam logic [9:0] FL_BR    = 10'b01_0000_0000;
    localparam logic [9:0] FL_MDS   = 10'b00_0000_0010;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] flags();
        return {bus.PCWrite, bus.PCWriteCond, bus.IRWrite,
                bus.MemRead, bus.MemWrite, bus.RegWrite,
                bus.RegDst, bus.MemtoReg, bus.md_start,
                bus.illegal_op};
    endfunction

    task automatic look(input string tag, input logic [3:0] st,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] op, input logic [9:0] fl);
        chk({tag, ".st"}, 32'(bus.state_dbg), 32'(st));
        chk({tag, ".srca"}, 32'(bus.ALUSrcA), 32'(a));
        chk({tag, ".srcb"}, 32'(bus.ALUSrcB), 32'(b));
        chk({tag, ".aluop"}, 32'(bus.ALUOp), 32'(op));
        chk({tag, ".flags"}, 32'(flags()), 32'(fl));
    endtask

    task automatic step(input string tag, input logic [3:0] st,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] op, input logic [9:0] fl);
        @(negedge clk);
        look(tag, st, a, b, op, fl);
    endtask

    task automatic fetch(input string tag);
        step({tag, ".fetch"}, 4'd1, 2'b00, 2'b01, 3'b001, FL_FETCH);
    endtask

    task automatic decode(input string tag);
        step({tag, ".dec"}, 4'd2, 2'b00, 2'b11, 3'b001, FL_NONE);
    endtask

    task automatic r_type(input string tag, input logic [5:0] fn,
                          input logic [2:0] op);
        bus.opcode = 6'h00;
        bus.funct  = fn;
        fetch(tag);
        decode(tag);
        step({tag, ".ex"}, 4'd3, 2'b01, 2'b00, op, FL_NONE);
        step({tag, ".wb"}, 4'd4, 2'b00, 2'b00, 3'b000, FL_WBR);
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h20;
        bus.zero     = 1'b0;
        bus.md_busy  = 1'b0;

        repeat (2) @(negedge clk);
        look("rst", 4'd0, 2'b00, 2'b00, 3'b000, FL_NONE);
        rst_n = 1'b1;

        r_type("add", 6'h20, 3'b001);
        r_type("sub", 6'h22, 3'b010);
        r_type("and", 6'h24, 3'b011);
        r_type("or",  6'h25, 3'b100);
        r_type("slt", 6'h2A, 3'b111);

        bus.opcode = 6'h23;
        fetch("lw");
        decode("lw");
        step("lw.addr", 4'd7, 2'b01, 2'b10, 3'b001, FL_NONE);
        step("lw.rd0", 4'd8, 2'b00, 2'b00, 3'b000, FL_MRD);
        step("lw.rd1", 4'd8, 2'b00, 2'b00, 3'b000, FL_MRD);
        step("lw.wb", 4'd10, 2'b00, 2'b00, 3'b000, FL_WBM);

        bus.opcode = 6'h2B;
        fetch("sw");
        decode("sw");
        step("sw.addr", 4'd7, 2'b01, 2'b10, 3'b001, FL_NONE);
        step("sw.wr0", 4'd9, 2'b00, 2'b00, 3'b000, FL_MWR);
        step("sw.wr1", 4'd9, 2'b00, 2'b00, 3'b000, FL_MWR);

        bus.opcode = 6'h04;
        bus.zero   = 1'b1;
        fetch("beq");
        decode("beq");
        step("beq.br", 4'd11, 2'b01, 2'b00, 3'b010, FL_BR);
        bus.zero   = 1'b0;

        bus.opcode = 6'h08;
        fetch("addi");
        decode("addi");
        step("addi.ex", 4'd5, 2'b01, 2'b10, 3'b001, FL_NONE);
        step("addi.wb", 4'd6, 2'b00, 2'b00, 3'b000, FL_WBI);

        bus.opcode  = 6'h00;
        bus.funct   = 6'h18;
        bus.md_busy = 1'b1;
        fetch("mult");
        decode("mult");
        step("mult.st", 4'd12, 2'b00, 2'b00, 3'b000, FL_MDS);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("mult.w%0d", i), 4'd13,
                 2'b00, 2'b00, 3'b000, FL_NONE);
        end
        bus.md_busy = 1'b0;

        bus.funct = 6'h1A;
        fetch("div");
        decode("div");
        step("div.st", 4'd12, 2'b00, 2'b00, 3'b000, FL_MDS);
        step("div.w0", 4'd13, 2'b00, 2'b00, 3'b000, FL_NONE);

        bus.opcode = 6'h3F;
        fetch("ill");
        decode("ill");
        step("ill.pulse", 4'd1, 2'b00, 2'b01, 3'b001, FL_FILL);
        bus.opcode = 6'h00;
        bus.funct  = 6'h01;
        decode("illf");
        step("illf.pulse", 4'd1, 2'b00, 2'b01, 3'b001, FL_FILL);
        bus.funct = 6'h20;
        decode("post");
        step("post.ex", 4'd3, 2'b01, 2'b00, 3'b001, FL_NONE);

        #2 rst_n = 1'b0;
        #1 look("midrst", 4'd0, 2'b00, 2'b00, 3'b000, FL_NONE);
        @(negedge clk);
        look("rsthold", 4'd0, 2'b00, 2'b00, 3'b000, FL_NONE);
        rst_n = 1'b1;
        fetch("rel");
        decode("rel");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
